uart_tx_arbiter: RTL and testbench
==================================

# uart_tx_arbiter

Shares the single UART transmitter (`async_transmitter`, 100 MHz domain) between two byte sources: keyboard ASCII from the PS/2 path, and host-bound reply sequences from the VT100 parser (status and cursor-position reports). Each source gets its own small FIFO. A round-robin arbiter drains the FIFOs into the transmitter's start/busy handshake. A parser reply packet is never interleaved with keyboard bytes.

## Interface
Parameters:
- `FIFO_DEPTH_LOG2`, default 3: each FIFO holds 2^N entries (8).
- `DATA_WIDTH`, default 8: byte width on all data ports.

Ports:
- `clk` in 1: system clock (clk100M domain).
- `rst` in 1: asynchronous, active-high reset.
- `kbValid` in 1: one-cycle strobe; the keyboard byte on `kbData` is written.
- `kbData` in 8: keyboard ASCII byte.
- `kbDropped` out 1: one-cycle pulse when a keyboard byte is discarded because its FIFO is full.
- `hostValid` in 1: write strobe for a parser reply byte.
- `hostData` in 8: parser reply byte.
- `hostLast` in 1: marks the final byte of a reply packet; qualified by `hostValid`.
- `hostFull` out 1: host FIFO full; the parser must not assert `hostValid` while this is high.
- `hostOverflow` out 1: sticky flag, set when a host write hits a full FIFO; cleared only by reset.
- `txStart` out 1: one-cycle start pulse to the transmitter.
- `txData` out 8: byte to transmit; stable from the `txStart` cycle until `txBusy` falls.
- `txBusy` in 1: transmitter busy.
- `idle` out 1: high when both FIFOs are empty and the FSM is in IDLE.

## Operation
- FIFOs:
  - Keyboard FIFO is 8 bits wide; host FIFO is 9 bits wide ({last, data}).
  - Write and pop in the same cycle are legal, including when full (pop frees the slot first) and when empty (no bypass; the written byte is poppable next cycle).
  - Pointers are N+1 bits and wrap naturally. Full = MSBs differ and the low bits are equal.
- Write to a full FIFO:
  - Keyboard: the byte is discarded and `kbDropped` pulses.
  - Host: the byte is discarded and `hostOverflow` is set.
- FSM states: IDLE, LOAD, START, ACK, DRAIN.
  - IDLE: if `txBusy`=0 and some FIFO is eligible, the arbiter grants it and pops one entry → LOAD.
  - LOAD: the popped entry is registered into `txData`/`lastByte` → START.
  - START: `txStart`=1 for exactly this cycle → ACK.
  - ACK: wait for `txBusy`=1 → DRAIN.
  - DRAIN: wait for `txBusy`=0 → IDLE.
- Eligibility:
  - If `hostLock`=1, only the host FIFO is eligible. The keyboard waits even when the host FIFO is empty.
  - Otherwise, both non-empty → round-robin grant opposite to `lastGrant`; one non-empty → that one.
- `hostLock` is set when a host byte with last=0 is granted and cleared when a host byte with last=1 is granted.
- `lastGrant` is updated on every grant.

## Timing
- Reset values:
  - `txStart`=0, `txData`=0, `kbDropped`=0, `hostOverflow`=0, `hostFull`=0, `idle`=1.
  - FIFOs empty, FSM=IDLE, `hostLock`=0, `lastGrant`=host (keyboard wins the first tie).
- Latency: a write strobe in cycle N into empty FIFOs, with the FSM in IDLE and `txBusy`=0, gives `txStart`=1 in cycle N+3 (N+1 IDLE grant, N+2 LOAD, N+3 START).
- Back-to-back bytes: the next `txStart` comes no earlier than 3 cycles after `txBusy` falls.
- Reset mid-transfer: the transmitter may still be busy. IDLE requires `txBusy`=0 before the first grant, so no start is issued into a busy transmitter.
- `hostFull` is combinational from the pointers and reflects same-cycle pops only on the next cycle (conservative).

## Structure
- Shared package holds:
  - `TxArbState_t`, an enum of the five states.
  - `TX_FIFO_DEPTH_LOG2` constant.
  - `TxSource_t` (KB/HOST) for `lastGrant`.
- One sub-module, `tx_byte_fifo`: parameterised width/depth, synchronous write/pop, async-reset pointers, `full`/`empty` outputs. It is instantiated twice: width 8 for the keyboard, width 9 for the host.

## Test plan
- Single keyboard byte 0x41 with `txBusy` modelled as a 10-cycle busy pulse starting the cycle after `txStart` → `txStart` in cycle N+3, `txData`=0x41, then `idle`=1.
- Host packet 1B 5B 33 3B 35 52 (last on 0x52), while keyboard bytes 0x61, 0x62 arrive mid-packet → all six host bytes are sent contiguously, then 0x61, 0x62.
- Both FIFOs holding single-byte packets (host last=1), written simultaneously after reset → order is kb, host, kb, host (round-robin, keyboard first).
- Nine keyboard writes while `txBusy` is held high → 8 bytes are stored, `kbDropped` pulses once on the ninth, and 8 bytes transmit once busy releases. Repeat on the host FIFO: `hostFull`=1 after 8 writes, and `hostOverflow` is set by the ninth and stays set.
- Assert `rst` during DRAIN with `txBusy` still high → outputs return to their reset values immediately. After reset release, a queued byte is not started until `txBusy` falls.

Source files
------------

// File: rtl/uart_tx_arbiter_pkg.sv
// Shared types and constants for the UART transmit arbiter slice.
package uart_tx_arbiter_pkg;

  localparam int unsigned TX_FIFO_DEPTH_LOG2 = 3;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_START,
    ST_ACK,
    ST_DRAIN
  } TxArbState_t;

  typedef enum logic {
    SRC_KB,
    SRC_HOST
  } TxSource_t;

endpackage : uart_tx_arbiter_pkg

// File: rtl/uart_tx_arbiter_fifo.sv
// Small synchronous FIFO feeding the transmit arbiter; read data is the head entry.
module tx_byte_fifo #(
  parameter int unsigned WIDTH      = 8,
  parameter int unsigned DEPTH_LOG2 = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  output logic [WIDTH-1:0] rd_data,
  output logic             full,
  output logic             empty
);

  localparam int unsigned DEPTH = 2 ** DEPTH_LOG2;

  logic [WIDTH-1:0]    mem [DEPTH];
  logic [DEPTH_LOG2:0] wr_ptr;
  logic [DEPTH_LOG2:0] rd_ptr;
  logic                do_pop;
  logic                do_wr;

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[DEPTH_LOG2] != rd_ptr[DEPTH_LOG2]) &&
                   (wr_ptr[DEPTH_LOG2-1:0] == rd_ptr[DEPTH_LOG2-1:0]);
  assign do_pop  = rd_en && !empty;
  // A pop in the same cycle frees the slot, so a write into a full FIFO is accepted then.
  assign do_wr   = wr_en && (!full || do_pop);
  assign rd_data = mem[rd_ptr[DEPTH_LOG2-1:0]];

  // Storage array: written on accepted writes only.
  always_ff @(posedge clk) begin
    if (do_wr) begin
      mem[wr_ptr[DEPTH_LOG2-1:0]] <= wr_data;
    end
  end

  // Read/write pointers, N+1 bits so full and empty are distinguishable.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_wr)  wr_ptr <= wr_ptr + 1'b1;
      if (do_pop) rd_ptr <= rd_ptr + 1'b1;
    end
  end

endmodule : tx_byte_fifo

// File: rtl/uart_tx_arbiter.sv
// Shares one UART transmitter between keyboard bytes and parser reply packets.
module uart_tx_arbiter
  import uart_tx_arbiter_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH_LOG2 = TX_FIFO_DEPTH_LOG2,
  parameter int unsigned DATA_WIDTH      = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  kbValid,
  input  logic [DATA_WIDTH-1:0] kbData,
  output logic                  kbDropped,
  input  logic                  hostValid,
  input  logic [DATA_WIDTH-1:0] hostData,
  input  logic                  hostLast,
  output logic                  hostFull,
  output logic                  hostOverflow,
  output logic                  txStart,
  output logic [DATA_WIDTH-1:0] txData,
  input  logic                  txBusy,
  output logic                  idle
);

  TxArbState_t           state;
  TxSource_t             last_grant;
  logic                  host_lock;
  logic [DATA_WIDTH-1:0] pend_data;

  logic                  kb_full;
  logic                  kb_empty;
  logic [DATA_WIDTH-1:0] kb_rd;
  logic                  host_full;
  logic                  host_empty;
  logic [DATA_WIDTH:0]   host_rd;
  logic                  grant_kb;
  logic                  grant_host;

  tx_byte_fifo #(
    .WIDTH      (DATA_WIDTH),
    .DEPTH_LOG2 (FIFO_DEPTH_LOG2)
  ) u_kb_fifo (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (kbValid),
    .wr_data (kbData),
    .rd_en   (grant_kb),
    .rd_data (kb_rd),
    .full    (kb_full),
    .empty   (kb_empty)
  );

  tx_byte_fifo #(
    .WIDTH      (DATA_WIDTH + 1),
    .DEPTH_LOG2 (FIFO_DEPTH_LOG2)
  ) u_host_fifo (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (hostValid),
    .wr_data ({hostLast, hostData}),
    .rd_en   (grant_host),
    .rd_data (host_rd),
    .full    (host_full),
    .empty   (host_empty)
  );

  assign hostFull = host_full;
  assign idle     = kb_empty && host_empty && (state == ST_IDLE);

  // Grant selection: host-only while a reply packet is open, otherwise round-robin.
  always_comb begin
    grant_kb   = 1'b0;
    grant_host = 1'b0;
    if (state == ST_IDLE && !txBusy) begin
      if (host_lock) begin
        grant_host = !host_empty;
      end else if (!kb_empty && !host_empty) begin
        if (last_grant == SRC_HOST) grant_kb   = 1'b1;
        else                        grant_host = 1'b1;
      end else begin
        grant_kb   = !kb_empty;
        grant_host = !host_empty;
      end
    end
  end

  // Arbiter FSM: pop on grant, load the byte, pulse start, follow the busy handshake.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= ST_IDLE;
      last_grant <= SRC_HOST;
      host_lock  <= 1'b0;
      pend_data  <= '0;
      txData     <= '0;
      txStart    <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (grant_kb) begin
            pend_data  <= kb_rd;
            last_grant <= SRC_KB;
            state      <= ST_LOAD;
          end else if (grant_host) begin
            pend_data  <= host_rd[DATA_WIDTH-1:0];
            last_grant <= SRC_HOST;
            host_lock  <= !host_rd[DATA_WIDTH];
            state      <= ST_LOAD;
          end
        end
        ST_LOAD: begin
          txData  <= pend_data;
          txStart <= 1'b1;
          state   <= ST_START;
        end
        ST_START: begin
          txStart <= 1'b0;
          state   <= ST_ACK;
        end
        ST_ACK: begin
          if (txBusy) state <= ST_DRAIN;
        end
        ST_DRAIN: begin
          if (!txBusy) state <= ST_IDLE;
        end
        default: begin
          txStart <= 1'b0;
          state   <= ST_IDLE;
        end
      endcase
    end
  end

  // Write-side error reporting: one-cycle drop pulse and sticky overflow flag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      kbDropped    <= 1'b0;
      hostOverflow <= 1'b0;
    end else begin
      kbDropped <= kbValid && kb_full && !grant_kb;
      if (hostValid && host_full && !grant_host) hostOverflow <= 1'b1;
    end
  end

endmodule : uart_tx_arbiter

// File: tb/tb_uart_tx_arbiter.sv
// Scoreboard bench for uart_tx_arbiter with a transaction-level arbitration model.
module tb_uart_tx_arbiter;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       kbValid = 1'b0;
  logic [7:0] kbData = '0;
  logic       kbDropped;
  logic       hostValid = 1'b0;
  logic [7:0] hostData = '0;
  logic       hostLast = 1'b0;
  logic       hostFull;
  logic       hostOverflow;
  logic       txStart;
  logic [7:0] txData;
  logic       txBusy;
  logic       idle;

  uart_tx_arbiter #(
    .FIFO_DEPTH_LOG2 (3),
    .DATA_WIDTH      (8)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .kbValid      (kbValid),
    .kbData       (kbData),
    .kbDropped    (kbDropped),
    .hostValid    (hostValid),
    .hostData     (hostData),
    .hostLast     (hostLast),
    .hostFull     (hostFull),
    .hostOverflow (hostOverflow),
    .txStart      (txStart),
    .txData       (txData),
    .txBusy       (txBusy),
    .idle         (idle)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Transmitter model: busy for 10 cycles starting the cycle after txStart.
  int   busy_cnt = 0;
  logic force_busy = 1'b0;
  always @(posedge clk) begin
    if (txStart)           busy_cnt <= 10;
    else if (busy_cnt > 0) busy_cnt <= busy_cnt - 1;
  end
  assign txBusy = (busy_cnt != 0) || force_busy;

  int vectors = 0;
  int errs    = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s actual=0x%0h required=0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: accepted bytes per source with the cycle they were written.
  typedef struct {
    logic [7:0] d;
    logic       l;
    int         w;
  } item_t;

  item_t      kb_m[$];
  item_t      host_m[$];
  logic [7:0] exp_q[$];   // directed tests: order stated by the test plan
  bit         m_lock = 1'b0;
  bit         m_last_host = 1'b1;

  int   start_cnt = 0;
  int   last_start_cyc = 0;
  int   last_busy_cyc = -100;
  int   drop_cnt = 0;
  bit   prev_start = 1'b0;
  bit   have_cur = 1'b0;
  bit   seen_busy = 1'b0;
  logic [7:0] cur_byte = '0;

  // Monitor: on every start, work out which byte the arbitration rules require.
  always @(negedge clk) begin
    if (rst) begin
      m_lock      = 1'b0;
      m_last_host = 1'b1;
      have_cur    = 1'b0;
      seen_busy   = 1'b0;
      prev_start  = 1'b0;
    end else begin
      if (txStart) begin
        int  g;
        int  src;
        bit  ko;
        bit  ho;
        item_t it;
        chk("start_one_cycle", {31'd0, prev_start}, 32'd0);
        chk("start_gap_after_busy", {31'd0, (cyc - last_busy_cyc) >= 3}, 32'd1);
        g  = cyc - 2;
        ko = 1'b0;
        ho = 1'b0;
        if (kb_m.size() > 0)   ko = (kb_m[0].w < g);
        if (host_m.size() > 0) ho = (host_m[0].w < g);
        src = -1;
        if (m_lock)        src = ho ? 1 : -1;
        else if (ko && ho) src = m_last_host ? 0 : 1;
        else if (ko)       src = 0;
        else if (ho)       src = 1;
        if (src < 0) begin
          vectors++;
          errs++;
          $display("FAIL unexpected_start actual=0x%0h required=no start (t=%0t)", txData, $time);
        end else if (src == 0) begin
          it = kb_m.pop_front();
          chk("model_kb_byte", {24'd0, txData}, {24'd0, it.d});
          m_last_host = 1'b0;
        end else begin
          it = host_m.pop_front();
          chk("model_host_byte", {24'd0, txData}, {24'd0, it.d});
          m_last_host = 1'b1;
          m_lock      = !it.l;
        end
        if (exp_q.size() > 0) begin
          logic [7:0] e;
          e = exp_q.pop_front();
          chk("plan_order", {24'd0, txData}, {24'd0, e});
        end
        cur_byte       = txData;
        have_cur       = 1'b1;
        seen_busy      = 1'b0;
        start_cnt++;
        last_start_cyc = cyc;
      end else if (have_cur) begin
        chk("tx_data_stable", {24'd0, txData}, {24'd0, cur_byte});
        if (txBusy) seen_busy = 1'b1;
        else if (seen_busy) begin
          have_cur  = 1'b0;
          seen_busy = 1'b0;
        end
      end
      prev_start = txStart;
      if (txBusy)    last_busy_cyc = cyc;
      if (kbDropped) drop_cnt++;
    end
  end

  // One stimulus cycle; accepted writes are recorded in the model.
  task automatic drive(input bit kv, input logic [7:0] kd, input bit hv, input logic [7:0] hd,
                       input bit hl, input bit kacc = 1'b1, input bit hacc = 1'b1);
    kbValid   = kv;
    kbData    = kd;
    hostValid = hv;
    hostData  = hd;
    hostLast  = hl;
    if (kv && kacc) kb_m.push_back(item_t'{d: kd, l: 1'b0, w: cyc});
    if (hv && hacc) host_m.push_back(item_t'{d: hd, l: hl, w: cyc});
    @(posedge clk);
    #1;
    kbValid   = 1'b0;
    hostValid = 1'b0;
    hostLast  = 1'b0;
  endtask

  task automatic idle_cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_drain(input string name, input int budget);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(posedge clk);
      #1;
      if (idle && !txBusy && kb_m.size() == 0 && host_m.size() == 0 && exp_q.size() == 0) begin
        ok = 1'b1;
        break;
      end
    end
    chk(name, {31'd0, ok}, 32'd1);
  endtask

  task automatic wait_start(input string name, input int s0, input int budget);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(posedge clk);
      #1;
      if (start_cnt > s0) begin
        ok = 1'b1;
        break;
      end
    end
    chk(name, {31'd0, ok}, 32'd1);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_txStart"},      {31'd0, txStart},      32'd0);
    chk({tag, "_txData"},       {24'd0, txData},       32'd0);
    chk({tag, "_kbDropped"},    {31'd0, kbDropped},    32'd0);
    chk({tag, "_hostOverflow"}, {31'd0, hostOverflow}, 32'd0);
    chk({tag, "_hostFull"},     {31'd0, hostFull},     32'd0);
    chk({tag, "_idle"},         {31'd0, idle},         32'd1);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    kb_m.delete();
    host_m.delete();
    exp_q.delete();
    idle_cycles(2);
    rst = 1'b0;
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog actual=still running required=finished");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int n;
    int s0;
    int d0;
    bit kv;
    bit hv;

    do_reset();
    chk_reset_outputs("reset");

    // Single keyboard byte: start three cycles after the strobe.
    n  = cyc;
    s0 = start_cnt;
    exp_q.push_back(8'h41);
    drive(1'b1, 8'h41, 1'b0, 8'h00, 1'b0);
    wait_start("kb_single_start", s0, 20);
    chk("kb_latency", last_start_cyc - n, 32'd3);
    wait_drain("kb_single_drain", 100);
    chk("kb_single_idle", {31'd0, idle}, 32'd1);

    // Host reply packet with keyboard bytes arriving mid-packet.
    exp_q = '{8'h1B, 8'h5B, 8'h33, 8'h3B, 8'h35, 8'h52, 8'h61, 8'h62};
    drive(1'b0, 8'h00, 1'b1, 8'h1B, 1'b0);
    drive(1'b0, 8'h00, 1'b1, 8'h5B, 1'b0);
    drive(1'b1, 8'h61, 1'b1, 8'h33, 1'b0);
    drive(1'b1, 8'h62, 1'b1, 8'h3B, 1'b0);
    drive(1'b0, 8'h00, 1'b1, 8'h35, 1'b0);
    drive(1'b0, 8'h00, 1'b1, 8'h52, 1'b1);
    wait_drain("packet_drain", 400);

    // Simultaneous single-byte packets right after reset: kb, host, kb, host.
    do_reset();
    exp_q = '{8'h11, 8'h21, 8'h12, 8'h22};
    drive(1'b1, 8'h11, 1'b1, 8'h21, 1'b1);
    drive(1'b1, 8'h12, 1'b1, 8'h22, 1'b1);
    wait_drain("rr_drain", 400);

    // Keyboard FIFO overfill while the transmitter is held busy.
    force_busy = 1'b1;
    d0 = drop_cnt;
    for (int i = 0; i < 9; i++) begin
      if (i < 8) exp_q.push_back(8'h30 + 8'(i));
      drive(1'b1, 8'h30 + 8'(i), 1'b0, 8'h00, 1'b0, (i < 8), 1'b1);
    end
    idle_cycles(2);
    chk("kb_dropped_count", drop_cnt - d0, 32'd1);
    force_busy = 1'b0;
    wait_drain("kb_fill_drain", 600);

    // Host FIFO overfill while the transmitter is held busy.
    force_busy = 1'b1;
    for (int i = 0; i < 8; i++) begin
      exp_q.push_back(8'h40 + 8'(i));
      drive(1'b0, 8'h00, 1'b1, 8'h40 + 8'(i), 1'b1);
    end
    chk("host_full_after_8", {31'd0, hostFull}, 32'd1);
    chk("host_overflow_before_9", {31'd0, hostOverflow}, 32'd0);
    drive(1'b0, 8'h00, 1'b1, 8'h48, 1'b1, 1'b1, 1'b0);
    chk("host_overflow_after_9", {31'd0, hostOverflow}, 32'd1);
    force_busy = 1'b0;
    wait_drain("host_fill_drain", 600);
    chk("host_overflow_sticky", {31'd0, hostOverflow}, 32'd1);
    chk("host_full_after_drain", {31'd0, hostFull}, 32'd0);

    // Reset in DRAIN with the transmitter still busy.
    s0 = start_cnt;
    exp_q.push_back(8'h77);
    drive(1'b1, 8'h77, 1'b0, 8'h00, 1'b0);
    wait_start("pre_reset_start", s0, 20);
    idle_cycles(4);
    force_busy = 1'b1;
    rst = 1'b1;
    #1;
    chk_reset_outputs("midreset");
    kb_m.delete();
    host_m.delete();
    exp_q.delete();
    idle_cycles(2);
    rst = 1'b0;
    s0 = start_cnt;
    exp_q.push_back(8'h5A);
    drive(1'b1, 8'h5A, 1'b0, 8'h00, 1'b0);
    idle_cycles(20);
    chk("no_start_while_busy", start_cnt - s0, 32'd0);
    force_busy = 1'b0;
    wait_drain("post_reset_drain", 200);
    chk("post_reset_one_start", start_cnt - s0, 32'd1);

    // Randomised traffic against the model; queues kept short so nothing overflows.
    for (int i = 0; i < 400; i++) begin
      kv = ($urandom_range(0, 3) == 0) && (kb_m.size() < 6);
      hv = ($urandom_range(0, 3) == 0) && (host_m.size() < 6);
      drive(kv, 8'($urandom), hv, 8'($urandom), ($urandom_range(0, 2) == 0));
    end
    drive(1'b0, 8'h00, 1'b1, 8'($urandom), 1'b1);
    wait_drain("random_drain", 4000);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end

endmodule : tb_uart_tx_arbiter
